ram16k_arb2: RTL

Two-requester round-robin arbiter and sequencer for a single-port RAM16K (16-bit data, 14-bit address, enable/write/read strobes, synchronous read). It accepts independent read or write requests from two clients, serialises them onto the one RAM port with fair alternation, and returns read data to the issuing client with a one-cycle valid pulse. It sits between the RAM16K instance and the two datapath blocks that share it.

---
 rtl/ram16k_arb2.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram16k_arb2.sv
// Round-robin arbiter/sequencer that shares one synchronous-read RAM16K port
// between two clients and returns read data with a one-cycle valid pulse.
module ram16k_arb2 #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [13:0] adr0,
    input  logic [13:0] adr1,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        ram_e,
    output logic        ram_w,
    output logic        ram_r,
    output logic [13:0] ram_adr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg;
    logic        last_reg;   // last-served client; also the client owning the access in flight
    logic        we_reg;
    logic        pick;
    logic        accept;
    logic        capture;
    logic        we_sel;
    logic [13:0] adr_sel;
    logic [15:0] din_sel;
    logic        rvalid_reg [2];
    logic [15:0] rdata_reg  [2];

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        busy       = (state_reg != IDLE);
        pick       = (req0 && req1) ? ~last_reg : req1;
        we_sel     = pick ? we1  : we0;
        adr_sel    = pick ? adr1 : adr0;
        din_sel    = pick ? din1 : din0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                gnt0       = ~last_reg;
                gnt1       = last_reg;
                state_next = we_reg ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_reg == 2'd0) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            last_reg  <= 1'b1;
            we_reg    <= 1'b0;
            ram_e     <= 1'b0;
            ram_w     <= 1'b1;
            ram_r     <= 1'b0;
            ram_adr   <= 14'd0;
            ram_din   <= 16'd0;
        end else begin
            state_reg <= state_next;
            // Strobes fall back to the idle encoding unless an access is launched.
            ram_e     <= 1'b0;
            ram_w     <= 1'b1;
            ram_r     <= 1'b0;
            if (accept) begin
                last_reg <= pick;
                we_reg   <= we_sel;
                ram_e    <= 1'b1;
                ram_w    <= ~we_sel;
                ram_r    <= 1'b1;
                ram_adr  <= adr_sel;
                ram_din  <= din_sel;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= 2'(RD_LAT - 1);
            end else if (state_reg == WAIT && cnt_reg != 2'd0) begin
                cnt_reg <= cnt_reg - 2'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= 16'd0;
            end else begin
                rvalid_reg[gi] <= capture && (last_reg == 1'(gi));
                if (capture && (last_reg == 1'(gi))) begin
                    rdata_reg[gi] <= ram_dout;
                end
            end
        end
    end

    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata0  = rdata_reg[0];
    assign rdata1  = rdata_reg[1];

endmodule
